// File: rtl/comp_window_tracker.sv
// comp_window_tracker: running max/min over a WINDOW-sample window using one shared
// magnitude comparator. Optional comparator one-hot check: COMP_ONEHOT_CHECK_EN.
module comp_window_tracker #(
   parameter int WIDTH  = 4,
   parameter int WINDOW = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        in_valid,
   input  logic [WIDTH-1:0]            in_data,
   output logic                        in_ready,
   output logic [WIDTH-1:0]            cmp_a,
   output logic [WIDTH-1:0]            cmp_b,
   input  logic                        cmp_e,
   input  logic                        cmp_l,
   input  logic                        cmp_g,
   output logic [WIDTH-1:0]            max_out,
   output logic [WIDTH-1:0]            min_out,
   output logic [$clog2(WINDOW+1)-1:0] cnt_out,
   output logic                        done,
   output logic                        cmp_err
);

   localparam int CW = $clog2(WINDOW + 1);
   localparam logic [CW-1:0] WIN_LEN = CW'(WINDOW);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMP_MAX,
      S_CMP_MIN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic [WIDTH-1:0] min_q, min_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    cnt_inc;
   logic             accept;

   assign cnt_inc  = cnt_q + CW'(1);
   assign in_ready = (state_q == S_IDLE) && !clear;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      max_d   = max_q;
      min_d   = min_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      cmp_a   = '0;
      cmp_b   = '0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (cnt_q == '0) begin
                  // First sample seeds both extremes without using the comparator.
                  max_d = in_data;
                  min_d = in_data;
                  cnt_d = CW'(1);
                  if (WINDOW == 1) state_d = S_DONE;
               end else begin
                  s_d     = in_data;
                  state_d = S_CMP_MAX;
               end
            end
         end
         S_CMP_MAX: begin
            cmp_a = s_q;
            cmp_b = max_q;
            if (cmp_g) max_d = s_q;
            state_d = S_CMP_MIN;
         end
         S_CMP_MIN: begin
            cmp_a = s_q;
            cmp_b = min_q;
            if (cmp_l) min_d = s_q;
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == WIN_LEN) ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q <= S_IDLE;
         max_q   <= '0;
         min_q   <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         max_q   <= max_d;
         min_q   <= min_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
      end
   end

   assign max_out = max_q;
   assign min_out = min_q;
   assign cnt_out = cnt_q;

`ifdef COMP_ONEHOT_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (((state_q == S_CMP_MAX) || (state_q == S_CMP_MIN)) &&
          !$onehot({cmp_e, cmp_l, cmp_g}))
         err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) err_q <= 1'b0;
      else                err_q <= err_d;
   end

   assign cmp_err = err_q;
`else
   logic unused_cmp_e;
   assign unused_cmp_e = cmp_e;
   assign cmp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_comp_window_tracker.sv
// Self-checking bench for comp_window_tracker (WIDTH=4, WINDOW=4) with a
// behavioural comparator and a queue-based window max/min reference model.
module tb_comp_window_tracker;

   localparam int WIDTH  = 4;
   localparam int WINDOW = 4;
   localparam int CW     = $clog2(WINDOW + 1);

   logic             clk;
   logic             reset;
   logic             clear;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic [WIDTH-1:0] cmp_a;
   logic [WIDTH-1:0] cmp_b;
   logic             cmp_e;
   logic             cmp_l;
   logic             cmp_g;
   logic [WIDTH-1:0] max_out;
   logic [WIDTH-1:0] min_out;
   logic [CW-1:0]    cnt_out;
   logic             done;
   logic             cmp_err;
   logic             stub_bad;

   int n_pass  = 0;
   int n_total = 0;

   logic [WIDTH-1:0] win[$];
   logic [WIDTH-1:0] mdl_max;
   logic [WIDTH-1:0] mdl_min;
   logic             exp_err;

   comp_window_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .cmp_a    (cmp_a),
      .cmp_b    (cmp_b),
      .cmp_e    (cmp_e),
      .cmp_l    (cmp_l),
      .cmp_g    (cmp_g),
      .max_out  (max_out),
      .min_out  (min_out),
      .cnt_out  (cnt_out),
      .done     (done),
      .cmp_err  (cmp_err)
   );

   // Magnitude comparator; the stub forces an illegal e=l=1 result.
   always_comb begin
      if (stub_bad) begin
         cmp_e = 1'b1;
         cmp_l = 1'b1;
         cmp_g = 1'b0;
      end else begin
         cmp_e = (cmp_a == cmp_b);
         cmp_l = (cmp_a <  cmp_b);
         cmp_g = (cmp_a >  cmp_b);
      end
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      win.delete();
      mdl_max = '0;
      mdl_min = '0;
   endtask

   // Called at a negedge with the DUT idle; offers one sample and follows it through.
   task automatic do_sample(input logic [WIDTH-1:0] v);
      bit first;
      first = (win.size() == 0);
      chk("ready_before", in_ready, 1);
      in_valid = 1'b1;
      in_data  = v;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = WIDTH'($urandom);
      if (!first) begin
         chk("ready_cmpmax", in_ready, 0);
         chk("cmpmax_a", cmp_a, v);
         chk("cmpmax_b", cmp_b, mdl_max);
         @(negedge clk);
         chk("ready_cmpmin", in_ready, 0);
         chk("cmpmin_a", cmp_a, v);
         chk("cmpmin_b", cmp_b, mdl_min);
         @(negedge clk);
      end
      win.push_back(v);
      mdl_max = win[0];
      mdl_min = win[0];
      foreach (win[i]) begin
         if (win[i] > mdl_max) mdl_max = win[i];
         if (win[i] < mdl_min) mdl_min = win[i];
      end
      if (win.size() == WINDOW) begin
         chk("done_pulse", done, 1);
         chk("ready_done", in_ready, 0);
         chk("max_final", max_out, mdl_max);
         chk("min_final", min_out, mdl_min);
         @(negedge clk);
         chk("done_single", done, 0);
         chk("cnt_wrap", cnt_out, 0);
         win.delete();
      end else begin
         chk("done_idle", done, 0);
         chk("cnt_run", cnt_out, win.size());
      end
      chk("max_run", max_out, mdl_max);
      chk("min_run", min_out, mdl_min);
      chk("idle_cmp_a", cmp_a, 0);
   endtask

   logic [10:0] rdy_pat;
   logic [10:0] done_pat;
   int          accepts;

   initial begin
`ifdef COMP_ONEHOT_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      reset    = 1'b1;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      stub_bad = 1'b0;
      model_reset();

      // Reset held for two cycles
      @(negedge clk);
      @(negedge clk);
      chk("rst_max", max_out, 0);
      chk("rst_min", min_out, 0);
      chk("rst_cnt", cnt_out, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_err", cmp_err, 0);
      chk("rst_cmp_b", cmp_b, 0);
      reset = 1'b0;
      @(negedge clk);

      // Directed window
      do_sample(4'd5);
      do_sample(4'd9);
      do_sample(4'd2);
      do_sample(4'd9);
      chk("w1_max", max_out, 9);
      chk("w1_min", min_out, 2);

      // Ties
      do_sample(4'd7);
      do_sample(4'd7);
      do_sample(4'd7);
      do_sample(4'd7);
      chk("tie_max", max_out, 7);
      chk("tie_min", min_out, 7);

      // Backpressure: valid held high with sample 3 for one full window
      rdy_pat  = 11'b00010010011;
      done_pat = 11'b10000000000;
      accepts  = 0;
      in_valid = 1'b1;
      in_data  = 4'd3;
      for (int c = 0; c < 11; c++) begin
         chk($sformatf("bp_ready_%0d", c), in_ready, rdy_pat[c]);
         chk($sformatf("bp_done_%0d", c), done, done_pat[c]);
         if (in_ready) accepts++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("bp_accepts", accepts, 4);
      chk("bp_max", max_out, 3);
      chk("bp_min", min_out, 3);
      chk("bp_cnt", cnt_out, 0);
      mdl_max = 4'd3;
      mdl_min = 4'd3;
      @(negedge clk);

      // Randomized windows with random idle gaps
      for (int w = 0; w < 4; w++) begin
         for (int s = 0; s < WINDOW; s++) begin
            do_sample(WIDTH'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      // Clear during CMP_MAX of the second sample
      do_sample(4'd6);
      in_valid = 1'b1;
      in_data  = 4'd1;
      @(negedge clk);
      clear = 1'b1;
      chk("clr_ready_low", in_ready, 0);
      @(negedge clk);
      chk("clr_cnt", cnt_out, 0);
      chk("clr_max", max_out, 0);
      chk("clr_min", min_out, 0);
      chk("clr_ready_held", in_ready, 0);
      @(negedge clk);
      chk("clr_no_accept", cnt_out, 0);
      clear    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("clr_after_cnt", cnt_out, 0);
      chk("clr_after_ready", in_ready, 1);
      model_reset();

      // Non-one-hot comparator result
      do_sample(4'd8);
      stub_bad = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'd12;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("stub_max_hold", max_out, 8);
      chk("stub_min_upd", min_out, 12);
      chk("stub_cnt", cnt_out, 2);
      chk("stub_err", cmp_err, exp_err);
      stub_bad = 1'b0;
      repeat (3) @(negedge clk);
      chk("stub_err_sticky", cmp_err, exp_err);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("err_cleared", cmp_err, 0);
      chk("final_cnt", cnt_out, 0);
      model_reset();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
